// File: rtl/fifo_drain_32.sv
// Splits each 64-bit word from an upstream registered-read FIFO into two 32-bit beats
// on a valid/ready stream, counting the words that have been fully emitted.
module fifo_drain_32 #(
  parameter int HI_FIRST = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [63:0]      fifo_data,
  output logic             fifo_rd_en,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        pop_ok;
  logic [31:0] first_half;
  logic [31:0] second_half;

  // Beats are taken straight from the FIFO's read register, which holds until the next pop.
  assign first_half  = (HI_FIRST != 0) ? fifo_data[63:32] : fifo_data[31:0];
  assign second_half = (HI_FIRST != 0) ? fifo_data[31:0]  : fifo_data[63:32];
  assign pop_ok      = enable && !fifo_empty && !rst;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_count <= '0;
    end else begin
      state <= state_next;
      if (state == SECOND && out_ready) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    fifo_rd_en = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    case (state)
      IDLE: begin
        fifo_rd_en = pop_ok;
        if (pop_ok) begin
          state_next = FIRST;
        end
      end
      FIRST: begin
        out_valid = 1'b1;
        out_data  = first_half;
        if (out_ready) begin
          state_next = SECOND;
        end
      end
      SECOND: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = second_half;
        // Popping during the final accept lets the next word follow with no bubble.
        if (out_ready) begin
          fifo_rd_en = pop_ok;
          state_next = pop_ok ? FIRST : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
